fetch_queue_unit: RTL and testbench
===================================

# fetch_queue_unit

Front-end fetch block for the superscalar core. It owns the fetch PC, reads instruction memory, and buffers fetched instructions in a small in-order queue. It presents the queue head to the fetch-to-decode pipeline register as PCF / PCPlus4F / InstrF. Consumption is governed by the same `en` that stalls that register, so stalls are absorbed by the queue instead of stopping instruction memory every cycle.

## Interface

Parameters:
- DEPTH, 4, queue entries; power of two, >= 2
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- ImemAddr  output  32  instruction memory read address; always equals the fetch PC
- ImemRdata  input  32  instruction word at ImemAddr, valid in the same cycle
- ImemReady  input  1  ImemRdata is valid this cycle
- en  input  1  decode-side enable; the head entry is consumed on a clock edge when en && ValidF
- FlushF  input  1  redirect request (taken branch or jump resolved in execute)
- PCTargetE  input  32  redirect target; sampled when FlushF=1
- PCF  output  32  head entry PC
- PCPlus4F  output  32  head entry PC + 4
- InstrF  output  32  head entry instruction
- ValidF  output  1  queue is non-empty
- Count  output  $clog2(DEPTH)+1  number of occupied entries

## Operation

State:
- FetchPC register.
- DEPTH-entry storage, each entry {PC, PC+4, Instr}.
- Read pointer and write pointer, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
- Count register.

Per-cycle control signals:
- pop = en && ValidF && !FlushF
- push = ImemReady && !FlushF && (Count < DEPTH || pop)

Push:
- Write {FetchPC, FetchPC+4, ImemRdata} at the write pointer.
- Write pointer advances by 1; FetchPC <= FetchPC + 4.
- 32-bit additions wrap modulo 2^32.

Pop:
- Read pointer advances by 1.

Count update:
- +1 on push only.
- -1 on pop only.
- Unchanged when both or neither occur.

Flush (FlushF=1) overrides everything else:
- Read pointer, write pointer and Count <= 0.
- FetchPC <= PCTargetE.
- No push and no pop that cycle.
- ImemRdata is discarded.

Outputs:
- Head outputs are driven combinationally from the entry at the read pointer while ValidF=1.
- When empty: PCF=0, PCPlus4F=0, InstrF=32'h0000_0013 (addi x0,x0,0, a NOP).
- ImemAddr = FetchPC combinationally.
- ValidF = (Count != 0).

Boundary conditions:
- Full with no pop: push is blocked; FetchPC holds; ImemAddr is re-presented every cycle.
- Full with pop in the same cycle: push is allowed; Count stays at DEPTH.
- Empty with en=1: no pop; outputs stay at their empty values.
- ImemReady=0: no push; FetchPC holds.
- Count never exceeds DEPTH and never goes below 0.

## Timing

- Reset (rst=1 at a clock edge) sets:
  - FetchPC=RESET_PC and both pointers 0.
  - Count=0, ValidF=0.
  - PCF=0, PCPlus4F=0, InstrF=32'h0000_0013.
  - ImemAddr=RESET_PC.
- rst takes priority over FlushF, push and pop. Asserting rst mid-stream discards all entries at that edge.
- Fetch latency: an instruction pushed at edge N is visible at the head (ValidF=1) after edge N, with no same-cycle bypass. With ImemReady=1, the first ValidF=1 appears one cycle after rst deasserts.
- Steady-state throughput is 1 instruction per cycle when en=1 and ImemReady=1.
- After a flush at edge N:
  - ImemAddr=PCTargetE during cycle N+1.
  - The target instruction is at the head after edge N+1.
  - Redirect penalty: one empty cycle seen by decode.

## Test plan

- Reset, then ImemReady=1, en=0 for 6 cycles, RESET_PC=0 -> Count reaches 4 and stays; ImemAddr holds at 32'h10; head PCF=0, PCPlus4F=4.
- From full, en=1 for 8 cycles with ImemRdata = address-derived pattern -> consecutive PCF 0,4,8,...,28, one per cycle; Count stays 4 (push and pop together every cycle).
- Streaming with FlushF=1 and PCTargetE=32'h200 mid-run -> that edge: Count=0, ValidF=0. Next cycle: ImemAddr=32'h200. The following cycle: PCF=32'h200, PCPlus4F=32'h204.
- ImemReady toggled 1,0,1,0 with en=1 from empty -> ValidF alternates; Count never exceeds 1; no PC is skipped or duplicated.
- FetchPC=32'hFFFF_FFFC via flush, then one push -> entry PCPlus4F=0; next ImemAddr=0.
- rst asserted with Count=3 -> after that edge: Count=0, ValidF=0, InstrF=32'h0000_0013, ImemAddr=RESET_PC.

Source files
------------

// File: rtl/fetch_queue_unit.sv
// Fetch front end: owns the fetch PC, reads instruction memory and holds fetched
// instructions in a small in-order queue whose head feeds the fetch/decode register.
module fetch_queue_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [31:0]              ImemAddr,
  input  logic [31:0]              ImemRdata,
  input  logic                     ImemReady,
  input  logic                     en,
  input  logic                     FlushF,
  input  logic [31:0]              PCTargetE,
  output logic [31:0]              PCF,
  output logic [31:0]              PCPlus4F,
  output logic [31:0]              InstrF,
  output logic                     ValidF,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [31:0]   NOP_INSTR  = 32'h0000_0013;

  // Handshakes: the memory side transfers on a cycle where ImemReady=1 and the
  // queue can accept (not full, or popping); the decode side transfers on a cycle
  // where ValidF=1 and en=1. FlushF cancels both transfers in its cycle.

  logic [31:0]   r_fetch_pc;
  logic [AW-1:0] r_rptr;
  logic [AW-1:0] r_wptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_pc_mem    [DEPTH];
  logic [31:0]   r_pc4_mem   [DEPTH];
  logic [31:0]   r_instr_mem [DEPTH];

  logic          w_valid;
  logic          w_pop;
  logic          w_push;
  logic [31:0]   w_fetch_pc4;

  assign w_valid     = (r_count != '0);
  assign w_pop       = en && w_valid && !FlushF;
  assign w_push      = ImemReady && !FlushF && ((r_count < FULL_COUNT) || w_pop);
  assign w_fetch_pc4 = r_fetch_pc + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_rptr     <= '0;
      r_wptr     <= '0;
      r_count    <= '0;
    end else if (FlushF) begin
      r_fetch_pc <= PCTargetE;
      r_rptr     <= '0;
      r_wptr     <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_fetch_pc <= w_fetch_pc4;
        r_wptr     <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_ONE;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_ONE;
      end
    end
  end

  // Entry storage needs no reset; occupancy is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_pc_mem[r_wptr]    <= r_fetch_pc;
      r_pc4_mem[r_wptr]   <= w_fetch_pc4;
      r_instr_mem[r_wptr] <= ImemRdata;
    end
  end

  always_comb begin
    PCF      = 32'h0;
    PCPlus4F = 32'h0;
    InstrF   = NOP_INSTR;
    if (w_valid) begin
      PCF      = r_pc_mem[r_rptr];
      PCPlus4F = r_pc4_mem[r_rptr];
      InstrF   = r_instr_mem[r_rptr];
    end
  end

  assign ImemAddr = r_fetch_pc;
  assign ValidF   = w_valid;
  assign Count    = r_count;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_fetch_queue_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [31:0] ImemAddr;
  logic [31:0] ImemRdata;
  logic        ImemReady;
  logic        en;
  logic        FlushF;
  logic [31:0] PCTargetE;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic [31:0] InstrF;
  logic        ValidF;
  logic [2:0]  Count;

  int checks   = 0;
  int failures = 0;

  // Reference model: fetch PC plus a queue of {pc, instr} entries.
  logic [31:0] m_fetch_pc;
  logic [63:0] exp_q[$];

  fetch_queue_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .ImemAddr(ImemAddr), .ImemRdata(ImemRdata),
    .ImemReady(ImemReady), .en(en), .FlushF(FlushF), .PCTargetE(PCTargetE),
    .PCF(PCF), .PCPlus4F(PCPlus4F), .InstrF(InstrF), .ValidF(ValidF), .Count(Count)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- helpers ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [63:0] head;
    chk("imem_addr", ImemAddr, m_fetch_pc);
    chk("count", 32'(Count), 32'(exp_q.size()));
    chk("valid", 32'(ValidF), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      chk("pcf", PCF, head[63:32]);
      chk("pcplus4f", PCPlus4F, head[63:32] + 32'd4);
      chk("instrf", InstrF, head[31:0]);
    end else begin
      chk("pcf_empty", PCF, 32'h0);
      chk("pcplus4f_empty", PCPlus4F, 32'h0);
      chk("instrf_empty", InstrF, NOP);
    end
  endtask

  // ---------------- driver ----------------
  // Drives one cycle of inputs, advances the model at the edge, checks at negedge.
  task automatic step(input logic r, input logic rdy, input logic e,
                      input logic fl, input logic [31:0] tgt);
    logic m_pop;
    logic m_push;
    logic [31:0] word;
    word      = mem_word(m_fetch_pc);
    rst       = r;
    ImemReady = rdy;
    en        = e;
    FlushF    = fl;
    PCTargetE = tgt;
    ImemRdata = rdy ? word : $urandom();
    @(posedge clk);
    if (r) begin
      m_fetch_pc = RESET_PC;
      exp_q.delete();
    end else if (fl) begin
      m_fetch_pc = tgt;
      exp_q.delete();
    end else begin
      m_pop  = e && (exp_q.size() != 0);
      m_push = rdy && ((exp_q.size() < DEPTH) || m_pop);
      if (m_pop) void'(exp_q.pop_front());
      if (m_push) begin
        exp_q.push_back({m_fetch_pc, word});
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
    @(negedge clk);
    check_model();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m_fetch_pc = 32'hx;
    rst = 1'b1; ImemReady = 1'b0; en = 1'b0; FlushF = 1'b0;
    PCTargetE = 32'h0; ImemRdata = 32'h0;

    // Reset state
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 32'h1234);
    chk("rst_count", 32'(Count), 0);
    chk("rst_instr", InstrF, NOP);
    chk("rst_addr", ImemAddr, RESET_PC);

    // Fill with no consumption
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0);
    chk("full_count", 32'(Count), 4);
    chk("full_addr", ImemAddr, 32'h10);
    chk("full_pcf", PCF, 32'h0);
    chk("full_pc4", PCPlus4F, 32'h4);

    // Stream from full: push and pop together each cycle
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 1, 0, 0);
      chk("stream_pcf", PCF, 32'(4 * (i + 1)));
      chk("stream_count", 32'(Count), 4);
    end

    // Flush mid-stream
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 1, 32'h200);
    chk("flush_count", 32'(Count), 0);
    chk("flush_valid", 32'(ValidF), 0);
    chk("flush_addr", ImemAddr, 32'h200);
    step(0, 1, 1, 0, 0);
    chk("tgt_pcf", PCF, 32'h200);
    chk("tgt_pc4", PCPlus4F, 32'h204);

    // ImemReady toggling from empty with en=1
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, (i % 2) == 0, 1, 0, 0);
      chk("toggle_valid", 32'(ValidF), 32'((i % 2) == 0));
      chk("toggle_count_le1", 32'(Count <= 3'd1), 1);
    end

    // Fetch PC wrap-around
    step(0, 0, 0, 1, 32'hFFFF_FFFC);
    step(0, 1, 0, 0, 0);
    chk("wrap_pc4", PCPlus4F, 32'h0);
    chk("wrap_addr", ImemAddr, 32'h0);

    // Reset with three entries held
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("pre_rst_count", 32'(Count), 3);
    step(1, 1, 1, 0, 0);
    chk("rst3_count", 32'(Count), 0);
    chk("rst3_valid", 32'(ValidF), 0);
    chk("rst3_instr", InstrF, NOP);
    chk("rst3_addr", ImemAddr, RESET_PC);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 70,
           $urandom_range(0, 99) < 55,
           $urandom_range(0, 99) < 6,
           $urandom() & 32'hFFFF_FFFC);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
